// File: rtl/block_unloader.sv
// Captures one NBYTES-wide block and streams it MSB byte first; first byte valid the cycle after load.
// Holds dout and state while dout_ready_i is low; load_ready_o only in IDLE; done_o pulses after last byte.
module block_unloader #(
   parameter int NBYTES = 16,
   parameter int CW     = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [8*NBYTES-1:0]   block_in_i,
   input  logic                  load_i,
   output logic                  load_ready_o,
   output logic [7:0]            dout_o,
   output logic                  dout_valid_o,
   input  logic                  dout_ready_i,
   output logic                  done_o,
   output logic                  overrun_o
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

   state_t              state_q;
   logic [8*NBYTES-1:0] shift_q;
   logic [8*NBYTES-1:0] shift_d;
   logic [CW-1:0]       cnt_q;
   logic [CW-1:0]       cnt_d;
   logic                done_q;
   logic                overrun_q;

   assign shift_d = {shift_q[8*NBYTES-9:0], 8'h00};
   assign cnt_d   = cnt_q + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load_i) begin
                  shift_q <= block_in_i;
                  cnt_q   <= '0;
                  state_q <= SEND;
               end
            end
            SEND: begin
               // A load while streaming is dropped; only the sticky flag records it.
               if (load_i) begin
                  overrun_q <= 1'b1;
               end
               if (dout_ready_i) begin
                  shift_q <= shift_d;
                  if (cnt_q == LAST_IDX) begin
                     cnt_q   <= '0;
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
         endcase
      end
   end

   assign load_ready_o = (state_q == IDLE);
   assign dout_valid_o = (state_q == SEND);
   assign dout_o       = (state_q == SEND) ? shift_q[8*NBYTES-1 -: 8] : 8'h00;
   assign done_o       = done_q;
   assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_block_unloader.sv
// Randomized scoreboard bench for block_unloader (16-byte instance plus a 32-byte loader round trip).
`timescale 1ns/1ps
module tb_block_unloader;
   localparam int NB  = 16;
   localparam int NB2 = 32;

   typedef struct {
      logic [7:0] b;
      bit         last;
   } exp_t;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic            rst_i, load_i, dout_ready_i;
   logic [8*NB-1:0] block_in_i;
   logic            load_ready_o, dout_valid_o, done_o, overrun_o;
   logic [7:0]      dout_o;

   logic             load2, rdy2, lr2, v2, done2, ovr2;
   logic [7:0]       d2;
   logic [8*NB2-1:0] blk2;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t e;
   bit   exp_done  = 1'b0;
   bit   hold_pend = 1'b0;
   logic [7:0] hold_val;
   int   xfers = 0;

   block_unloader #(.NBYTES(NB), .CW(6)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .block_in_i(block_in_i), .load_i(load_i),
      .load_ready_o(load_ready_o), .dout_o(dout_o), .dout_valid_o(dout_valid_o),
      .dout_ready_i(dout_ready_i), .done_o(done_o), .overrun_o(overrun_o)
   );

   block_unloader #(.NBYTES(NB2), .CW(6)) dut32 (
      .clk_i(clk_i), .rst_i(rst_i), .block_in_i(blk2), .load_i(load2),
      .load_ready_o(lr2), .dout_o(d2), .dout_valid_o(v2),
      .dout_ready_i(rdy2), .done_o(done2), .overrun_o(ovr2)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: predicts each handshake one half-cycle ahead of the edge that performs it.
   always @(negedge clk_i) begin
      if (rst_i) begin
         exp_done  = 1'b0;
         hold_pend = 1'b0;
      end else begin
         chk("done", done_o, exp_done);
         if (exp_done) chk("load_ready_in_done_cycle", load_ready_o, 1'b1);
         chk("load_ready_vs_valid", load_ready_o, !dout_valid_o);
         if (!dout_valid_o) chk("idle_dout", dout_o, 8'h00);
         if (hold_pend) begin
            chk("valid_held", dout_valid_o, 1'b1);
            chk("dout_held", dout_o, hold_val);
         end
         hold_pend = 1'b0;
         exp_done  = 1'b0;
         if (dout_valid_o && dout_ready_i) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %0h expected none", dout_o);
            end else begin
               e = q.pop_front();
               chk("byte", dout_o, e.b);
               exp_done = e.last;
               xfers++;
            end
         end else if (dout_valid_o) begin
            hold_pend = 1'b1;
            hold_val  = dout_o;
         end
      end
   end

   // Loads blk in the current cycle, then steps until done; n = cycles from the load edge to done.
   // mode 0: ready high, 1: ready toggles 1,0,..., 2: random ready, 3: ready high plus a stray load.
   task automatic run_block(input logic [8*NB-1:0] blk, input int mode, output int n);
      block_in_i = blk;
      load_i     = 1'b1;
      for (int i = 0; i < NB; i++) begin
         q.push_back('{b: blk[8*(NB-1-i) +: 8], last: (i == NB-1)});
      end
      n = 0;
      do begin
         @(posedge clk_i); #1;
         load_i = 1'b0;
         n++;
         if (n == 1) chk("first_byte_latency", {dout_valid_o, dout_o}, {1'b1, blk[8*NB-1 -: 8]});
         if (mode == 3 && n == 4) begin
            load_i     = 1'b1;
            block_in_i = '1;
         end
         case (mode)
            0, 3:    dout_ready_i = 1'b1;
            1:       dout_ready_i = n[0];
            default: dout_ready_i = 1'($urandom_range(0, 1));
         endcase
      end while (!done_o && n < 300);
      if (!done_o) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles", n);
      end
   endtask

   initial begin
      int n, n2, cnt;
      logic [8*NB-1:0]  blk;
      logic [8*NB2-1:0] acc;
      bit seen_done;

      rst_i = 1'b1; load_i = 1'b0; dout_ready_i = 1'b0; block_in_i = '0;
      load2 = 1'b0; rdy2 = 1'b0; blk2 = '0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      chk("rst_load_ready", load_ready_o, 1'b1);
      chk("rst_valid", dout_valid_o, 1'b0);
      chk("rst_dout", dout_o, 8'h00);
      chk("rst_done", done_o, 1'b0);
      chk("rst_overrun", overrun_o, 1'b0);

      // Ready in IDLE must be ignored.
      dout_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 chk("idle_ignores_ready", dout_valid_o, 1'b0);

      for (int i = 0; i < NB; i++) blk[8*(NB-1-i) +: 8] = 8'(i);
      run_block(blk, 0, n);
      chk("cycles_ready_high", n, 17);
      run_block(blk, 1, n);
      chk("cycles_ready_toggle", n, 32);
      @(posedge clk_i); #1;
      chk("overrun_before", overrun_o, 1'b0);

      run_block(blk, 3, n);
      chk("cycles_with_stray_load", n, 17);
      chk("overrun_set", overrun_o, 1'b1);

      // Back-to-back: the second load is issued in the first block's done cycle.
      run_block({$urandom, $urandom, $urandom, $urandom}, 0, n);
      run_block({$urandom, $urandom, $urandom, $urandom}, 0, n2);
      chk("b2b_done_spacing", n2, 17);
      chk("overrun_sticky", overrun_o, 1'b1);

      for (int k = 0; k < 6; k++) begin
         run_block({$urandom, $urandom, $urandom, $urandom}, 2, n);
      end

      // Reset mid-stream after the fifth accepted byte.
      @(posedge clk_i); #1;
      xfers = 0;
      blk = {$urandom, $urandom, $urandom, $urandom};
      block_in_i = blk;
      load_i = 1'b1;
      dout_ready_i = 1'b1;
      for (int i = 0; i < NB; i++) q.push_back('{b: blk[8*(NB-1-i) +: 8], last: (i == NB-1)});
      cnt = 0;
      do begin
         @(posedge clk_i); #1;
         load_i = 1'b0;
         cnt++;
      end while (xfers < 5 && cnt < 100);
      chk("bytes_before_reset", xfers, 5);
      rst_i = 1'b1;
      q.delete();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk("midrst_valid", dout_valid_o, 1'b0);
      chk("midrst_load_ready", load_ready_o, 1'b1);
      chk("midrst_dout", dout_o, 8'h00);
      chk("midrst_overrun_cleared", overrun_o, 1'b0);
      @(posedge clk_i); #1;
      run_block({$urandom, $urandom, $urandom, $urandom}, 0, n);
      chk("cycles_after_reset", n, 17);
      dout_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 chk("queue_drained", q.size(), 0);

      // 32-byte instance: rebuild the block the way the serial loader shifts bytes in.
      for (int w = 0; w < 8; w++) blk2[32*w +: 32] = $urandom;
      chk("w32_load_ready", lr2, 1'b1);
      load2 = 1'b1;
      @(posedge clk_i); #1;
      load2 = 1'b0;
      acc = '0;
      cnt = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 300 && !seen_done; c++) begin
         rdy2 = 1'($urandom_range(0, 1));
         if (v2 && rdy2) begin
            acc = {acc[8*NB2-9:0], d2};
            cnt++;
         end
         @(posedge clk_i); #1;
         if (done2) seen_done = 1'b1;
      end
      chk("w32_byte_count", cnt, NB2);
      chk("w32_roundtrip", acc, blk2);
      chk("w32_done_seen", seen_done, 1'b1);
      chk("w32_overrun", ovr2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
